// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V counters, pixel requests to the pixel source, and
// sync/blank re-aligned with pixel data that returns PIPE cycles after the request.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned PIPE     = 2,
  parameter logic [23:0] UF_COLOR = 24'hFF00FF,
  parameter int unsigned X_W      = 11,
  parameter int unsigned Y_W      = 10
) (
  input  logic               CLOCK_PIX,
  input  logic               RESET_N,
  input  logic               en,
  input  logic               underflow_clr,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic               pix_req,
  output logic               frame_start,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  input  logic               pix_valid,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               underflow
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] HActX   = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HLastX  = X_W'(H_TOT - 1);
  localparam logic [X_W-1:0] HsBegX  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HsEndX  = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] VActY   = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VLastY  = Y_W'(V_TOT - 1);
  localparam logic [Y_W-1:0] VsBegY  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VsEndY  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [COLOR_W-1:0] UfR = UF_COLOR[23 -: COLOR_W];
  localparam logic [COLOR_W-1:0] UfG = UF_COLOR[15 -: COLOR_W];
  localparam logic [COLOR_W-1:0] UfB = UF_COLOR[7 -: COLOR_W];

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e         state_q;
  logic [X_W-1:0] h_q, h_nxt;
  logic [Y_W-1:0] v_q, v_nxt;
  logic           req_q, fs_q;
  logic           wrap, act_nxt, sof_nxt;

  always_comb begin
    wrap    = (h_q == HLastX) && (v_q == VLastY);
    h_nxt   = h_q + 1'b1;
    v_nxt   = v_q;
    if (h_q == HLastX) begin
      h_nxt = '0;
      v_nxt = (v_q == VLastY) ? '0 : v_q + 1'b1;
    end
    act_nxt = (h_nxt < HActX) && (v_nxt < VActY);
    sof_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  // pix_req/frame_start are registered from next-state values so they line up with the counters.
  always_ff @(posedge CLOCK_PIX or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          h_q   <= '0;
          v_q   <= '0;
          req_q <= en;
          fs_q  <= en;
          if (en) state_q <= StRun;
        end
        StRun: begin
          h_q   <= h_nxt;
          v_q   <= v_nxt;
          req_q <= act_nxt;
          fs_q  <= sof_nxt;
          if (!en) state_q <= StDrain;
        end
        StDrain: begin
          h_q <= h_nxt;
          v_q <= v_nxt;
          if (!en && wrap) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
          end else begin
            state_q <= en ? StRun : StDrain;
            req_q   <= act_nxt;
            fs_q    <= sof_nxt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign pix_req     = req_q;
  assign frame_start = fs_q;
  assign VGA_SYNC_N  = 1'b0;

  // {hs asserted, vs asserted, active}; all zero while idle.
  logic       running;
  logic [2:0] raw, dly;

  assign running = (state_q != StIdle);
  assign raw = {running && (h_q >= HsBegX) && (h_q < HsEndX),
                running && (v_q >= VsBegY) && (v_q < VsEndY),
                req_q};

  if (PIPE == 0) begin : g_nopipe
    assign dly = raw;
  end else begin : g_pipe
    logic [2:0] sr_q [PIPE];
    always_ff @(posedge CLOCK_PIX or negedge RESET_N) begin
      if (!RESET_N) begin
        for (int i = 0; i < int'(PIPE); i++) sr_q[i] <= '0;
      end else begin
        sr_q[0] <= raw;
        for (int i = 1; i < int'(PIPE); i++) sr_q[i] <= sr_q[i-1];
      end
    end
    assign dly = sr_q[PIPE-1];
  end

  logic uf_now;
  assign uf_now = dly[0] && !pix_valid;

  always_ff @(posedge CLOCK_PIX or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_HS      <= !HS_POL;
      VGA_VS      <= !VS_POL;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      underflow   <= 1'b0;
    end else begin
      VGA_HS      <= dly[2] ? HS_POL : !HS_POL;
      VGA_VS      <= dly[1] ? VS_POL : !VS_POL;
      VGA_BLANK_N <= dly[0];
      if (uf_now) begin
        VGA_R <= UfR;
        VGA_G <= UfG;
        VGA_B <= UfB;
      end else if (dly[0]) begin
        VGA_R <= pix_r;
        VGA_G <= pix_g;
        VGA_B <= pix_b;
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
      // A new underflow wins over a simultaneous clear.
      if (uf_now) underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing and pixel-output stage for the SoC video path, clocked by the pixel clock.
- Generates H/V counters, pixel request coordinates for the frame-buffer/GPU pixel source, and the sync/blank signals.
- Re-aligns sync and blank with pixel data returned after a fixed source latency.
- Generalises the fixed 640x480 video hookup to arbitrary modes and sync polarities.
- Adds frame-boundary enable/disable and underflow detection.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, HS asserted level (0 = active-low)
- VS_POL, 0, VS asserted level
- COLOR_W, 8, bits per colour channel
- PIPE, 2, pixel source latency in cycles from pix_req to pix_r/g/b (>=0)
- UF_COLOR, 24'hFF00FF, RGB substituted on underflow (top COLOR_W bits of each byte)
- X_W, 11, pix_x width
- Y_W, 10, pix_y width

Ports:
- CLOCK_PIX  in  1  pixel clock
- RESET_N  in  1  asynchronous active-low reset
- en  in  1  run request; sampled only at frame boundary
- underflow_clr  in  1  clears sticky underflow flag
- pix_x  out  X_W  current h counter
- pix_y  out  Y_W  current v counter
- pix_req  out  1  counters in active region while running
- frame_start  out  1  1-cycle pulse at (0,0) while running
- pix_r, pix_g, pix_b  in  COLOR_W  source pixel, valid PIPE cycles after pix_req
- pix_valid  in  1  source data valid, same timing as pix_r/g/b
- VGA_R, VGA_G, VGA_B  out  COLOR_W  registered colour
- VGA_HS, VGA_VS  out  1  registered syncs
- VGA_BLANK_N  out  1  registered, 1 in active video
- VGA_SYNC_N  out  1  constant 0
- underflow  out  1  sticky underflow flag

Behaviour:
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise.
  - h wraps H_TOT-1 -> 0 and increments v.
  - v wraps V_TOT-1 -> 0.
- Active region: h < H_ACTIVE and v < V_ACTIVE.
- HS asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS likewise on v.
- FSM:
  - IDLE: counters held at 0.
    - en=1 -> RUN. Counting starts the following cycle from (0,0); frame_start pulses on that cycle.
  - RUN: counting.
    - en=0 -> DRAIN.
  - DRAIN: counting continues to end of frame.
    - en=1 again before the frame wraps -> back to RUN, no gap.
    - Otherwise at wrap (h=H_TOT-1, v=V_TOT-1) -> IDLE with counters 0.
  - pix_req and frame_start are only asserted in RUN/DRAIN.
- Alignment: HS/VS/active bits pass through a PIPE-stage shift register, then one output register.
  - VGA_* reflect counter position p exactly PIPE+1 cycles after p.
- VGA_R/G/B: registered source pixel when the delayed active bit =1, else 0.
- In IDLE the shift register is loaded with inactive values. Outputs then settle to idle after PIPE+1 cycles:
  - HS = !HS_POL, VS = !VS_POL
  - BLANK_N = 0, RGB = 0
- Underflow: delayed active =1 and pix_valid=0 -> that pixel outputs UF_COLOR and underflow is set.
  - Set has priority over a simultaneous underflow_clr.
- Reset (any time, including mid-frame): FSM IDLE, counters 0, shift register inactive.
  - Outputs immediately: HS = !HS_POL, VS = !VS_POL, BLANK_N = 0, RGB = 0, underflow = 0.
  - pix_req = 0, frame_start = 0.

Test Plan:
- Reset asserted mid-frame -> all outputs go to idle values asynchronously. After release with en=1, frame_start pulses exactly once, 1 cycle after en is sampled.
- Default params, en=1 -> per line 800 cycles; VGA_HS low for outputs corresponding to h=656..751 (96 cycles), appearing 3 cycles after pix_x hits 656. Frame = 525 lines; VS low lines 490..491.
- Small mode (H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, PIPE=0), source returns pixel = pix_x -> VGA_R sequence 0,1,2,3,0,0,0 per line, BLANK_N 1,1,1,1,0,0,0, latency 1 cycle.
- HS_POL=1, VS_POL=1 -> syncs active-high, idle low; blank timing unchanged.
- Drop en at v=100 -> counters run to (H_TOT-1, V_TOT-1), then hold 0; no further frame_start. Re-raise en at v=200 in another run -> no gap, continuous frames.
- Hold pix_valid=0 for one active pixel -> that pixel outputs FF/00/FF and underflow=1 sticky. underflow_clr in the same cycle as a new underflow -> flag stays 1; clr alone -> 0 next cycle.
